// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: one FSM state per clock,
// Moore outputs except BRANCH PCWrite and the execute-state ALU op.
module mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst1,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    RTEXEC   = 4'd6,
    RTWB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    JAL      = 4'd10,
    JR       = 4'd11,
    IEXEC    = 4'd12,
    IWB      = 4'd13,
    SPARE    = 4'd14,
    RESET    = 4'd15
  } stateE;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  stateE stReg, stNext;

  logic isAdd, isSub, isAnd, isOr, isSlt, isJr;
  logic rtAlu;
  logic [2:0] funcOp;
  stateE decNext;
  logic badInstr;

  assign isAdd = (func == 6'b100000);
  assign isSub = (func == 6'b100010);
  assign isAnd = (func == 6'b100100);
  assign isOr  = (func == 6'b100101);
  assign isSlt = (func == 6'b101010);
  assign isJr  = (func == 6'b001000);
  assign rtAlu = isAdd | isSub | isAnd | isOr | isSlt;

  always_comb begin
    funcOp = ALU_ADD;
    unique case (1'b1)
      isSub:   funcOp = ALU_SUB;
      isAnd:   funcOp = ALU_AND;
      isOr:    funcOp = ALU_OR;
      isSlt:   funcOp = ALU_SLT;
      default: funcOp = ALU_ADD;
    endcase
  end

  always_comb begin
    decNext  = FETCH;
    badInstr = 1'b0;
    case (opc)
      OP_R: begin
        if (rtAlu)     decNext = RTEXEC;
        else if (isJr) decNext = JR;
        else           badInstr = 1'b1;
      end
      OP_LW, OP_SW:      decNext = MEMADR;
      OP_BEQ:            decNext = BRANCH;
      OP_J:              decNext = JUMP;
      OP_JAL:            decNext = JAL;
      OP_ADDI, OP_SLTI:  decNext = IEXEC;
      default:           badInstr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stReg   <= RESET;
      illegal <= 1'b0;
    end else begin
      stReg <= stNext;
      if (stReg == DECODE && badInstr)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    stNext       = FETCH;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst1      = 1'b0;
    JalSig1      = 1'b0;
    MemToReg     = 1'b0;
    JalSig2      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOperation = 3'b000;
    PCSrc        = 2'b00;
    case (stReg)
      FETCH: begin
        MemRead      = 1'b1;
        IRWrite      = 1'b1;
        ALUSrcB      = 2'b01;
        ALUOperation = ALU_ADD;
        PCWrite      = 1'b1;
        stNext       = DECODE;
      end
      DECODE: begin
        ALUSrcB      = 2'b11;
        ALUOperation = ALU_ADD;
        stNext       = decNext;
      end
      MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = ALU_ADD;
        if (opc == OP_LW)      stNext = MEMREAD;
        else if (opc == OP_SW) stNext = MEMWRITE;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        stNext  = MEMWB;
      end
      MEMWB:    RegWrite = 1'b1;
      MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      RTEXEC: begin
        ALUSrcA      = 1'b1;
        ALUOperation = funcOp;
        stNext       = RTWB;
      end
      RTWB: begin
        RegDst1  = 1'b1;
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSrc        = 2'b10;
        PCWrite      = zero;
      end
      JUMP: begin
        PCSrc   = 2'b01;
        PCWrite = 1'b1;
      end
      // $31 gets the already-incremented PC on the same edge as the jump
      JAL: begin
        PCSrc    = 2'b01;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        JalSig1  = 1'b1;
        JalSig2  = 1'b1;
      end
      JR: begin
        PCSrc   = 2'b11;
        PCWrite = 1'b1;
      end
      IEXEC: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        stNext       = IWB;
      end
      IWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      default: stNext = FETCH;
    endcase
  end

  assign state = stReg;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against an instruction-level
// trace model of the multicycle control sequence.
module tb_mc_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst1, JalSig1, MemToReg, JalSig2, RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOperation;
  logic [1:0] PCSrc;
  logic [3:0] state;
  logic       illegal;

  mc_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst1(RegDst1),
    .JalSig1(JalSig1), .MemToReg(MemToReg), .JalSig2(JalSig2),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOperation(ALUOperation), .PCSrc(PCSrc), .state(state),
    .illegal(illegal)
  );

  typedef struct packed {
    logic       pcw, iord, mrd, mwr, irw;
    logic       rdst, jal1, m2r, jal2, rw;
    logic       srcA;
    logic [1:0] srcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
  } ctlT;

  ctlT gotCtl;
  assign gotCtl = {PCWrite, IorD, MemRead, MemWrite, IRWrite,
                   RegDst1, JalSig1, MemToReg, JalSig2, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOperation, PCSrc};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   pend[$];
  int   cur;
  logic expIll;
  logic curBad;

  function automatic logic [2:0] rOp(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic logic isRAlu(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic ctlT expCtl(input int st, input logic [5:0] o,
                                 input logic [5:0] f, input logic z);
    ctlT c;
    c = '0;
    case (st)
      0: begin
        c.pcw = 1; c.mrd = 1; c.irw = 1; c.srcB = 2'b01; c.aluOp = 3'b010;
      end
      1: begin c.srcB = 2'b11; c.aluOp = 3'b010; end
      2: begin c.srcA = 1; c.srcB = 2'b10; c.aluOp = 3'b010; end
      3: begin c.mrd = 1; c.iord = 1; end
      4: c.rw = 1;
      5: begin c.mwr = 1; c.iord = 1; end
      6: begin c.srcA = 1; c.aluOp = rOp(f); end
      7: begin c.rdst = 1; c.m2r = 1; c.rw = 1; end
      8: begin c.srcA = 1; c.aluOp = 3'b110; c.pcSrc = 2'b10; c.pcw = z; end
      9: begin c.pcSrc = 2'b01; c.pcw = 1; end
      10: begin
        c.pcSrc = 2'b01; c.pcw = 1; c.rw = 1; c.jal1 = 1; c.jal2 = 1;
      end
      11: begin c.pcSrc = 2'b11; c.pcw = 1; end
      12: begin
        c.srcA = 1; c.srcB = 2'b10;
        c.aluOp = (o == 6'b001010) ? 3'b111 : 3'b010;
      end
      13: begin c.m2r = 1; c.rw = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // States visited after FETCH for one instruction
  function automatic void buildTrace(input logic [5:0] o,
                                     input logic [5:0] f);
    pend.delete();
    curBad = 1'b0;
    pend.push_back(1);
    case (o)
      6'b100011: begin pend.push_back(2); pend.push_back(3); pend.push_back(4); end
      6'b101011: begin pend.push_back(2); pend.push_back(5); end
      6'b000000: begin
        if (isRAlu(f)) begin pend.push_back(6); pend.push_back(7); end
        else if (f == 6'b001000) pend.push_back(11);
        else curBad = 1'b1;
      end
      6'b000100: pend.push_back(8);
      6'b000010: pend.push_back(9);
      6'b000011: pend.push_back(10);
      6'b001000, 6'b001010: begin pend.push_back(12); pend.push_back(13); end
      default: curBad = 1'b1;
    endcase
  endfunction

  task automatic pickInstr();
    logic [5:0] o, f;
    int r;
    r = $urandom_range(0, 19);
    o = 6'($urandom);
    f = 6'($urandom);
    case (r)
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: begin o = 0; f = 6'b100000; end
      3: begin o = 0; f = 6'b100010; end
      4: begin o = 0; f = 6'b100100; end
      5: begin o = 0; f = 6'b100101; end
      6: begin o = 0; f = 6'b101010; end
      7: begin o = 0; f = 6'b001000; end
      8: o = 6'b000100;
      9: o = 6'b000010;
      10: o = 6'b000011;
      11: o = 6'b001000;
      12: o = 6'b001010;
      13: o = 6'b111111;
      17, 18, 19: o = 0;
      default: ;
    endcase
    opc = o;
    func = f;
    buildTrace(o, f);
  endtask

  task automatic checkAll(input string tag, input int st);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".illegal"}, 32'(illegal), 32'(expIll));
    check({tag, ".ctl"}, 32'(gotCtl), 32'(expCtl(st, opc, func, zero)));
  endtask

  initial begin
    logic midDone;
    rst = 1'b0;
    opc = 6'd0;
    func = 6'd0;
    zero = 1'b0;
    expIll = 1'b0;
    curBad = 1'b0;
    midDone = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkAll("reset", 15);
    rst = 1'b1;
    cur = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0 || (cur == 2 && !midDone)) begin
        if (cur == 2) midDone = 1'b1;
        rst = 1'b0;
        expIll = 1'b0;
        #1;
        checkAll("asyncReset", 15);
        rst = 1'b1;
        pend.delete();
        cur = 0;
        continue;
      end
      zero = 1'($urandom);
      #1;
      checkAll($sformatf("st%0d", cur), cur);
      if (cur == 0) begin
        pickInstr();
        cur = pend.pop_front();
      end else if (pend.size() > 0) begin
        cur = pend.pop_front();
      end else begin
        if (cur == 1 && curBad) expIll = 1'b1;
        cur = 0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
